// File: rtl/router_pkg.sv
// router_pkg: shared router constants, header field positions and packet-length helper
package router_pkg;

    localparam int ROUTER_WIDTH = 8;
    localparam int ROUTER_DEPTH = 16;
    localparam int PKT_CNT_W    = 7;

    // header byte layout: destination address in the low bits, payload length above it
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

    // bytes still to come after a header: payload length plus the parity byte
    function automatic pkt_cnt_t pkt_bytes(input logic [ROUTER_WIDTH-1:0] hdr);
        return pkt_cnt_t'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + pkt_cnt_t'(1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: output-side packet FIFO of the 1x3 router
// Ports:
//   clock       rising-edge clock
//   resetn      synchronous active-low reset
//   soft_reset  synchronous flush from the synchronizer's read timeout
//   write_enb   write request from the synchronizer
//   read_enb    read request from the external port
//   lfd_state   data_in carries a header byte this cycle
//   data_in     byte to store
//   data_out    registered read data
//   full        all entries occupied
//   empty       no entries occupied
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = ROUTER_WIDTH,
    parameter int DEPTH = ROUTER_DEPTH,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] hdr;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    pkt_cnt_t         pkt_cnt;
    logic             clr;
    logic             wr_go;
    logic             rd_go;
    logic [WIDTH-1:0] rd_byte;

    // pointers carry an extra wrap bit so full and empty are distinguishable
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign clr     = !resetn || soft_reset;
    assign wr_go   = write_enb && !full;
    assign rd_go   = read_enb && !empty;
    assign rd_byte = mem[rd_ptr[AW-1:0]];

    // payload storage needs no reset; only the header flags must be cleared
    always_ff @(posedge clock) begin
        if (!clr && wr_go)
            mem[wr_ptr[AW-1:0]] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            hdr      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            data_out <= '0;
        end else begin
            if (wr_go) begin
                hdr[wr_ptr[AW-1:0]] <= lfd_state;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_go) begin
                data_out <= rd_byte;
                rd_ptr   <= rd_ptr + 1'b1;
                pkt_cnt  <= hdr[rd_ptr[AW-1:0]] ? pkt_bytes(rd_byte)
                          : (pkt_cnt != '0) ? pkt_cnt - 1'b1 : pkt_cnt;
            end else if (pkt_cnt == '0) begin
                data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed self-checking bench for router_fifo
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_full;
        logic       exp_empty;
        logic [6:0] exp_cnt;
    } vec_t;

    vec_t vecs [11];

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    // drive one cycle of inputs, then sample just after the rising edge
    task automatic cyc(input logic wr, input logic rd, input logic lfd, input logic [7:0] din);
        write_enb = wr;
        read_enb  = rd;
        lfd_state = lfd;
        data_in   = din;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_dout", 32'(data_out), 32'h00);
        chk("reset_cnt", 32'(dut.pkt_cnt), 32'd0);

        // packet round trip: header length 3, three payload bytes, parity
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, 7'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 8'h00, 1'b0, 1'b0, 7'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hA2, 8'h00, 1'b0, 1'b0, 7'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'hA3, 8'h00, 1'b0, 1'b0, 7'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h5E, 8'h00, 1'b0, 1'b0, 7'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0C, 1'b0, 1'b0, 7'd4};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA1, 1'b0, 1'b0, 7'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA2, 1'b0, 1'b0, 7'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 1'b0, 1'b0, 7'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5E, 1'b0, 1'b1, 7'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 7'd0};
        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].wr, vecs[i].rd, vecs[i].lfd, vecs[i].din);
            chk($sformatf("rt_dout[%0d]", i), 32'(data_out), 32'(vecs[i].exp_dout));
            chk($sformatf("rt_full[%0d]", i), 32'(full), 32'(vecs[i].exp_full));
            chk($sformatf("rt_empty[%0d]", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("rt_cnt[%0d]", i), 32'(dut.pkt_cnt), 32'(vecs[i].exp_cnt));
        end

        // full boundary: 16 writes fill, 17th is dropped
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
            chk($sformatf("fill_full[%0d]", i), 32'(full), (i == 15) ? 32'd1 : 32'd0);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'hFF);
        chk("drop_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("drain_dout[%0d]", i), 32'(data_out), 32'(8'h10 + 8'(i)));
            chk($sformatf("drain_empty[%0d]", i), 32'(empty), (i == 15) ? 32'd1 : 32'd0);
        end

        // simultaneous read and write while full: read wins, write dropped
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        chk("sim_full_pre", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("sim_full_full", 32'(full), 32'd0);
        chk("sim_full_dout", 32'(data_out), 32'h30);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("sim_full_drain[%0d]", i), 32'(data_out), 32'(8'h31 + 8'(i)));
        end
        chk("sim_full_end_empty", 32'(empty), 32'd1);

        // simultaneous read and write while empty: write accepted, read ignored
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_dout_clear", 32'(data_out), 32'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        chk("sim_empty_empty", 32'(empty), 32'd0);
        chk("sim_empty_dout", 32'(data_out), 32'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("sim_empty_read", 32'(data_out), 32'h77);
        chk("sim_empty_after", 32'(empty), 32'd1);

        // soft reset mid-packet discards concurrent write
        cyc(1'b1, 1'b0, 1'b1, 8'h14);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b0, 1'b0, 8'h01 + 8'(i));
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_hdr_dout", 32'(data_out), 32'h14);
        chk("sr_hdr_cnt", 32'(dut.pkt_cnt), 32'd6);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_pay_dout", 32'(data_out), 32'h01);
        chk("sr_pay_cnt", 32'(dut.pkt_cnt), 32'd5);
        soft_reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        soft_reset = 1'b0;
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_dout", 32'(data_out), 32'h00);
        chk("sr_cnt", 32'(dut.pkt_cnt), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("sr_write_discarded", 32'(empty), 32'd1);

        // hard reset mid-packet
        cyc(1'b1, 1'b0, 1'b1, 8'h08);
        cyc(1'b1, 1'b0, 1'b0, 8'h42);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("hr_pre_cnt", 32'(dut.pkt_cnt), 32'd3);
        resetn = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 8'h99);
        resetn = 1'b1;
        chk("hr_empty", 32'(empty), 32'd1);
        chk("hr_dout", 32'(data_out), 32'h00);
        chk("hr_cnt", 32'(dut.pkt_cnt), 32'd0);

        // wrap-around: pointers pass 2^(AW+1) without flag glitches
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i + 8'h50));
            chk($sformatf("wrap_wr_empty[%0d]", i), 32'(empty), 32'd0);
            chk($sformatf("wrap_wr_full[%0d]", i), 32'(full), 32'd0);
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("wrap_dout[%0d]", i), 32'(data_out), 32'(8'(i + 8'h50)));
            chk($sformatf("wrap_rd_empty[%0d]", i), 32'(empty), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
